fetch_redirect_controller: RTL and testbench
============================================

Name: fetch_redirect_controller

Overview:
- Sequences the instruction-fetch PC and applies redirects from the branch decoder unit, sepc/mepc and the trap unit.
- Drives a valid/ready request interface to instruction memory and tracks outstanding fetches.
- Squashes in-flight responses belonging to the old path and generates the IF/ID + ID/EX flush.
- Sits between the EX-stage branch decoder unit and the instruction memory port.

Parameters:
- Width, 32, address/data width.
- ResetVector, 0, first fetch address after reset.
- MaxOutstanding, 2, maximum accepted-but-unanswered fetches (>=1).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX-stage instruction valid
- pc_src  in  pc_src_t  branch decoder unit decision (branch_decoder_unit_pkg)
- ex_target  in  Width  PC+imm / rs1+imm target
- sepc  in  Width  supervisor return address
- mepc  in  Width  machine return address
- trap_req  in  1  trap taken this cycle
- trap_vector  in  Width  trap handler address
- stall  in  1  decode back-pressure
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  imem accepts request
- fetch_addr  out  Width  request address
- resp_valid  in  1  imem response valid (in order)
- resp_data  in  Width  fetched instruction
- inst_valid  out  1  response forwarded to IF/ID
- inst  out  Width  = resp_data
- flush  out  1  flush IF/ID and ID/EX
- pc  out  Width  current fetch PC

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - pc=ResetVector, state=Boot, outstanding=0, discard=0.
  - Outputs fetch_valid=0, flush=0, inst_valid=0.
- Reset mid-operation clears all state. The imem must be reset by the same reset, so no pre-reset responses are tracked.
- FSM:
  - Boot: fetch_valid=0 for exactly one cycle, then Run.
  - Run: normal operation, returns to Boot only on reset.
- Redirect decision (combinational, Run only):
  - trap_req=1 -> target=trap_vector.
  - Else if ex_valid=1:
    - Sepc -> sepc
    - Mepc -> mepc
    - PcOrReadDataPlusImm -> ex_target
    - PcPlus4 -> no redirect
  - Else no redirect.
  - trap_req has priority over any simultaneous pc_src.
  - Target bits [1:0] are forced to 00.
- Redirect cycle N:
  - flush=1 in cycle N only; fetch_valid=0 in cycle N.
  - At edge N: pc<=target, discard<=outstanding-resp_valid (saturated at 0), outstanding<=outstanding-resp_valid.
  - Redirect overrides stall.
- fetch_valid:
  - = state==Run & ~redirect & ~stall & outstanding<MaxOutstanding.
  - fetch_addr=pc.
  - fetch_valid/fetch_addr are not held stable across cycles when fetch_ready=0; they drop if stall rises or a redirect occurs.
- On accept (fetch_valid & fetch_ready): pc<=pc+4, modulo 2^Width (0xFFFFFFFC wraps to 0).
- Outstanding counter:
  - +1 on accept, -1 on resp_valid; both in the same cycle -> unchanged.
  - resp_valid with outstanding=0 is a protocol error: ignored, counter stays 0, inst_valid=0.
- Response filtering:
  - inst_valid = resp_valid & discard==0 & ~redirect & outstanding>0.
  - If resp_valid & discard>0: discard decrements and inst_valid=0.
  - inst = resp_data always.
- Latency:
  - inst_valid is combinational from resp_valid.
  - First fetch after a redirect is issued in cycle N+1.

Test Plan:
- Reset release, fetch_ready=1, resp every cycle -> cycle0 fetch_valid=0; cycles 1..3 fetch_addr=0x0,0x4,0x8; inst_valid follows resp_valid.
- MaxOutstanding=2, fetch_ready=1, no resp -> accepts at 0x0 and 0x4, then fetch_valid=0 until one resp_valid, then fetch 0x8.
- outstanding=2, ex_valid=1, pc_src=PcOrReadDataPlusImm, ex_target=0x103 -> flush=1 one cycle; next fetch_addr=0x100; next two resp_valid give inst_valid=0, third gives inst_valid=1.
- trap_req=1, trap_vector=0x200, same cycle ex_valid=1, pc_src=Mret, mepc=0x80 -> pc=0x200, flush=1.
- outstanding=1, stall=1, resp_valid=1, Sepc redirect sepc=0x40 -> inst_valid=0, flush=1, discard=0; next cycle fetch_addr=0x40 once stall=0.
- ex_valid=1 pc_src=PcPlus4 -> flush=0, sequential fetch continues; ex_valid=0 pc_src=Sepc -> flush=0. pc=0xFFFFFFFC accepted -> next fetch_addr=0x0.

Source files
------------

// File: rtl/fetch_redirect_controller.sv
// Instruction-fetch PC sequencer: issues imem requests, applies trap/xRET/jump
// redirects, squashes wrong-path responses and raises the IF/ID + ID/EX flush.
package branch_decoder_unit_pkg;
  typedef enum logic [1:0] {
    PcPlus4             = 2'd0,
    PcOrReadDataPlusImm = 2'd1,
    Sepc                = 2'd2,
    Mepc                = 2'd3
  } pc_src_t;
endpackage

module fetch_redirect_controller
  import branch_decoder_unit_pkg::*;
#(
  parameter int unsigned      Width          = 32,
  parameter logic [Width-1:0] ResetVector    = '0,
  parameter int unsigned      MaxOutstanding = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  pc_src_t          pc_src,
  input  logic [Width-1:0] ex_target,
  input  logic [Width-1:0] sepc,
  input  logic [Width-1:0] mepc,
  input  logic             trap_req,
  input  logic [Width-1:0] trap_vector,
  input  logic             stall,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [Width-1:0] fetch_addr,
  input  logic             resp_valid,
  input  logic [Width-1:0] resp_data,
  output logic             inst_valid,
  output logic [Width-1:0] inst,
  output logic             flush,
  output logic [Width-1:0] pc
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {Boot = 1'b0, Run = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [CntW-1:0]  out_q, out_d;
  logic [CntW-1:0]  disc_q, disc_d;
  logic [CntW-1:0]  out_dec;
  logic [Width-1:0] raw_target;
  logic             redirect;
  logic             accept;
  logic             resp_eff;

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Boot;
      pc_q    <= ResetVector;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  // Redirect decision, request issue, response filtering and next state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    disc_d      = disc_q;
    redirect    = 1'b0;
    raw_target  = pc_q;
    fetch_valid = 1'b0;
    accept      = 1'b0;
    inst_valid  = 1'b0;
    flush       = 1'b0;

    // A response with nothing outstanding is a protocol error and is ignored
    resp_eff = resp_valid && (out_q != '0);
    out_dec  = out_q - CntW'(resp_eff);

    case (state_q)
      Boot: state_d = Run;
      Run: begin
        if (trap_req) begin
          redirect   = 1'b1;
          raw_target = trap_vector;
        end else if (ex_valid) begin
          case (pc_src)
            Sepc: begin
              redirect   = 1'b1;
              raw_target = sepc;
            end
            Mepc: begin
              redirect   = 1'b1;
              raw_target = mepc;
            end
            PcOrReadDataPlusImm: begin
              redirect   = 1'b1;
              raw_target = ex_target;
            end
            default: ;
          endcase
        end
        fetch_valid = !redirect && !stall && (out_q < CntW'(MaxOutstanding));
      end
      default: state_d = Boot;
    endcase

    accept     = fetch_valid && fetch_ready;
    inst_valid = resp_valid && (disc_q == '0) && !redirect && (out_q != '0);
    flush      = redirect;

    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path
      pc_d   = {raw_target[Width-1:2], 2'b00};
      out_d  = out_dec;
      disc_d = out_dec;
    end else begin
      if (accept) pc_d = pc_q + Width'(4);
      out_d = out_dec + CntW'(accept);
      if (resp_eff && (disc_q != '0)) disc_d = disc_q - CntW'(1);
    end
  end

  assign fetch_addr = pc_q;
  assign pc         = pc_q;
  assign inst       = resp_data;

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Cycle-scripted bench for fetch_redirect_controller: per-cycle vector table
// plus a scoreboard of instructions expected to reach IF/ID.
module tb_fetch_redirect_controller;
  import branch_decoder_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  pc_src_t     pc_src;
  logic [31:0] ex_target;
  logic [31:0] sepc;
  logic [31:0] mepc;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        stall;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic        flush;
  logic [31:0] pc;

  fetch_redirect_controller dut (
    .clock      (clock),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .pc_src     (pc_src),
    .ex_target  (ex_target),
    .sepc       (sepc),
    .mepc       (mepc),
    .trap_req   (trap_req),
    .trap_vector(trap_vector),
    .stall      (stall),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_addr (fetch_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .inst_valid (inst_valid),
    .inst       (inst),
    .flush      (flush),
    .pc         (pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        exv;
    pc_src_t     src;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] tvec;
    logic        stl;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        chk;
    logic        e_fv;
    logic [31:0] e_fa;
    logic        e_flush;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic vec_t mk(logic rst, logic exv, pc_src_t src, logic [31:0] tgt,
                              logic trap, logic [31:0] tvec, logic stl, logic rdy,
                              logic rv, logic [31:0] rdata, logic chk, logic e_fv,
                              logic [31:0] e_fa, logic e_flush, logic e_iv,
                              logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.exv = exv; v.src = src; v.tgt = tgt; v.trap = trap; v.tvec = tvec;
    v.stl = stl; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.chk = chk; v.e_fv = e_fv;
    v.e_fa = e_fa; v.e_flush = e_flush; v.e_iv = e_iv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, got, exp);
    end
  endtask

  initial begin
    localparam pc_src_t P4 = PcPlus4;
    localparam pc_src_t IM = PcOrReadDataPlusImm;
    localparam pc_src_t SE = Sepc;
    localparam pc_src_t ME = Mepc;

    // Return addresses with low bits set exercise the target alignment
    sepc = 32'h0000_0041;
    mepc = 32'h0000_0082;

    //              rst exv src tgt       trap tvec          stl rdy rv rdata          chk fv fa            fl iv pc
    vecs.push_back(mk(1, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'hDEAD_0000,  1, 0, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h1111_0000,  1, 1, 32'h4,         0, 1, 32'h4));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h2222_0000,  1, 1, 32'h8,         0, 1, 32'h8));
    // Mid-run reset, then fill to MaxOutstanding with no responses
    vecs.push_back(mk(1, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h4,         0, 0, 32'h4));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h8));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h8));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h3333_0000,  1, 0, 32'h0,         0, 1, 32'h8));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h8,         0, 0, 32'h8));
    // Jump with two in flight: both old-path responses squashed
    vecs.push_back(mk(0, 1, IM, 32'h103,  0, 32'h0,          0, 1, 0, 32'h0,          1, 0, 32'h0,         1, 0, 32'hC));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h4444_0000,  1, 0, 32'h0,         0, 0, 32'h100));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h5555_0000,  1, 1, 32'h100,       0, 0, 32'h100));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 0, 1, 32'h6666_0000,  1, 1, 32'h104,       0, 1, 32'h104));
    // Trap beats a simultaneous mret
    vecs.push_back(mk(0, 1, ME, 32'h0,    1, 32'h200,        0, 1, 0, 32'h0,          1, 0, 32'h0,         1, 0, 32'h104));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h200,       0, 0, 32'h200));
    // sret under stall with a response in the same cycle
    vecs.push_back(mk(0, 1, SE, 32'h0,    0, 32'h0,          1, 1, 1, 32'h7777_0000,  1, 0, 32'h0,         1, 0, 32'h204));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          1, 1, 0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h40));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'h40,        0, 0, 32'h40));
    // PcPlus4 and non-valid EX never redirect
    vecs.push_back(mk(0, 1, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'h8888_0000,  1, 1, 32'h44,        0, 1, 32'h44));
    vecs.push_back(mk(0, 0, SE, 32'h0,    0, 32'h0,          0, 1, 1, 32'h9999_0000,  1, 1, 32'h48,        0, 1, 32'h48));
    // Trap to the top of the address space, then wrap
    vecs.push_back(mk(0, 0, P4, 32'h0,    1, 32'hFFFF_FFFC,  0, 1, 1, 32'hAAAA_0000,  1, 0, 32'h0,         1, 0, 32'h4C));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'hBBBB_0000,  1, 1, 32'h0,         0, 1, 32'h0));
    // mret with one in flight
    vecs.push_back(mk(0, 1, ME, 32'h0,    0, 32'h0,          0, 1, 0, 32'h0,          1, 0, 32'h0,         1, 0, 32'h4));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'hCCCC_0000,  1, 1, 32'h80,        0, 0, 32'h80));
    vecs.push_back(mk(0, 0, P4, 32'h0,    0, 32'h0,          0, 1, 1, 32'hDDDD_0000,  1, 1, 32'h84,        0, 1, 32'h84));

    reset = 1'b1; ex_valid = 1'b0; pc_src = PcPlus4; ex_target = '0; trap_req = 1'b0;
    trap_vector = '0; stall = 1'b0; fetch_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;

    foreach (vecs[i]) begin
      @(negedge clock);
      reset       = vecs[i].rst;
      ex_valid    = vecs[i].exv;
      pc_src      = vecs[i].src;
      ex_target   = vecs[i].tgt;
      trap_req    = vecs[i].trap;
      trap_vector = vecs[i].tvec;
      stall       = vecs[i].stl;
      fetch_ready = vecs[i].rdy;
      resp_valid  = vecs[i].rv;
      resp_data   = vecs[i].rdata;
      if (vecs[i].chk && vecs[i].e_iv) sb.push_back(vecs[i].rdata);
      #1;
      if (vecs[i].chk) begin
        check("fetch_valid", i, 32'(fetch_valid), 32'(vecs[i].e_fv));
        if (vecs[i].e_fv) check("fetch_addr", i, fetch_addr, vecs[i].e_fa);
        check("flush", i, 32'(flush), 32'(vecs[i].e_flush));
        check("inst_valid", i, 32'(inst_valid), 32'(vecs[i].e_iv));
        check("pc", i, pc, vecs[i].e_pc);
        if (inst_valid) begin
          if (sb.size() == 0) check("inst_unexpected", i, inst, 32'hFFFF_FFFF);
          else check("inst", i, inst, sb.pop_front());
        end
      end
    end

    @(negedge clock);
    check("sb_leftover", vecs.size(), 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
